// File: rtl/shot_ctl.sv
// rtl/shot_ctl.sv - Duck Hunt shot controller: trigger edge to shot event, hit test, ammo and cooldown
//
// Turns a press of the mouse trigger into a single shot event and tests it
// against the duck hitbox. It also enforces the per-round ammo budget and the
// cooldown that follows every shot.
//
// Optional feature: define SHOT_CTL_INF_AMMO_EN to enable infinite ammo.
// shots_left then stays at SHOTS_PER_ROUND, EMPTY is never entered and
// out_of_ammo stays 0. The cooldown and hit logic do not change.
//
// Ports:
//   clk          in   pixel clock, rising edge
//   rst          in   synchronous active-high reset
//   mouse_left   in   trigger level
//   mouse_xpos   in   cursor x (12 bits)
//   mouse_ypos   in   cursor y (12 bits)
//   duck_xpos    in   hitbox top-left x (12 bits)
//   duck_ypos    in   hitbox top-left y (12 bits)
//   duck_active  in   duck is shootable
//   round_start  in   one-cycle reload pulse
//   shot         out  one-cycle pulse per accepted shot
//   hit          out  one-cycle pulse with shot when it lands
//   miss         out  one-cycle pulse with shot when it does not land
//   shot_xpos    out  latched cursor x of the last shot
//   shot_ypos    out  latched cursor y of the last shot
//   shots_left   out  remaining ammo (4 bits)
//   out_of_ammo  out  high while in EMPTY

module shot_ctl #(
    parameter int SHOTS_PER_ROUND = 3,
    parameter int COOLDOWN_CYCLES = 650000,
    parameter int BOX_W           = 64,
    parameter int BOX_H           = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic [11:0] duck_xpos,
    input  logic [11:0] duck_ypos,
    input  logic        duck_active,
    input  logic        round_start,
    output logic        shot,
    output logic        hit,
    output logic        miss,
    output logic [11:0] shot_xpos,
    output logic [11:0] shot_ypos,
    output logic [3:0]  shots_left,
    output logic        out_of_ammo
);

    localparam int               CNT_W     = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [3:0]       AMMO_FULL = 4'(SHOTS_PER_ROUND);

    typedef enum logic [1:0] {
        S_READY,
        S_EVAL,
        S_COOLDOWN,
        S_EMPTY
    } state_t;

    state_t           r_state;
    logic             r_left_q;
    logic             r_left_d;
    logic [11:0]      r_xpos_q;
    logic [11:0]      r_ypos_q;
    logic [CNT_W-1:0] r_cnt;

    logic             w_rise;
    logic             w_in_x;
    logic             w_in_y;
    logic             w_hit;

    // Mouse inputs are registered once; left_d is one more delay for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_left_q <= 1'b0;
            r_left_d <= 1'b0;
            r_xpos_q <= 12'd0;
            r_ypos_q <= 12'd0;
        end else begin
            r_left_q <= mouse_left;
            r_left_d <= r_left_q;
            r_xpos_q <= mouse_xpos;
            r_ypos_q <= mouse_ypos;
        end
    end

    assign w_rise = r_left_q & ~r_left_d;

    // The comparison is done at 13 bits so that a box near 4095 does not wrap to 0.
    assign w_in_x = ({1'b0, shot_xpos} >= {1'b0, duck_xpos}) &&
                    ({1'b0, shot_xpos} <  ({1'b0, duck_xpos} + 13'(BOX_W)));
    assign w_in_y = ({1'b0, shot_ypos} >= {1'b0, duck_ypos}) &&
                    ({1'b0, shot_ypos} <  ({1'b0, duck_ypos} + 13'(BOX_H)));
    assign w_hit  = duck_active && w_in_x && w_in_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_READY;
            r_cnt       <= '0;
            shot        <= 1'b0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            shot_xpos   <= 12'd0;
            shot_ypos   <= 12'd0;
            shots_left  <= AMMO_FULL;
            out_of_ammo <= 1'b0;
        end else begin
            shot <= 1'b0;
            hit  <= 1'b0;
            miss <= 1'b0;
            case (r_state)
                S_READY: begin
                    // A reload that coincides with a click takes priority and drops the click.
                    if (round_start) begin
                        shots_left <= AMMO_FULL;
                    end else if (w_rise) begin
                        shot_xpos <= r_xpos_q;
                        shot_ypos <= r_ypos_q;
`ifndef SHOT_CTL_INF_AMMO_EN
                        shots_left <= shots_left - 4'd1;
`endif
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    // The shot always completes; a reload here only redirects the FSM to READY.
                    shot  <= 1'b1;
                    hit   <= w_hit;
                    miss  <= ~w_hit;
                    r_cnt <= '0;
                    if (round_start) begin
                        shots_left <= AMMO_FULL;
                        r_state    <= S_READY;
                    end else begin
                        r_state <= S_COOLDOWN;
                    end
                end
                S_COOLDOWN: begin
                    if (round_start) begin
                        shots_left <= AMMO_FULL;
                        r_cnt      <= '0;
                        r_state    <= S_READY;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
`ifdef SHOT_CTL_INF_AMMO_EN
                        r_state <= S_READY;
`else
                        if (shots_left != 4'd0) begin
                            r_state <= S_READY;
                        end else begin
                            r_state     <= S_EMPTY;
                            out_of_ammo <= 1'b1;
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EMPTY: begin
                    if (round_start) begin
                        shots_left  <= AMMO_FULL;
                        out_of_ammo <= 1'b0;
                        r_state     <= S_READY;
                    end
                end
                default: r_state <= S_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_shot_ctl.sv
// tb/tb_shot_ctl.sv - self-checking bench for shot_ctl: vector table, corner sequences, random run against a timeline model

module tb_shot_ctl;

    localparam int C    = 4;
    localparam int SPR  = 3;
    localparam int BOXW = 64;
    localparam int BOXH = 64;
    localparam int NEVER = 32'h7fffffff;
`ifdef SHOT_CTL_INF_AMMO_EN
    localparam int AMMO1 = SPR;
`else
    localparam int AMMO1 = SPR - 1;
`endif

    logic        clk;
    logic        rst;
    logic        mouse_left;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic [11:0] duck_xpos;
    logic [11:0] duck_ypos;
    logic        duck_active;
    logic        round_start;
    logic        shot;
    logic        hit;
    logic        miss;
    logic [11:0] shot_xpos;
    logic [11:0] shot_ypos;
    logic [3:0]  shots_left;
    logic        out_of_ammo;

    shot_ctl #(
        .SHOTS_PER_ROUND(SPR),
        .COOLDOWN_CYCLES(C),
        .BOX_W(BOXW),
        .BOX_H(BOXH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mouse_left(mouse_left),
        .mouse_xpos(mouse_xpos),
        .mouse_ypos(mouse_ypos),
        .duck_xpos(duck_xpos),
        .duck_ypos(duck_ypos),
        .duck_active(duck_active),
        .round_start(round_start),
        .shot(shot),
        .hit(hit),
        .miss(miss),
        .shot_xpos(shot_xpos),
        .shot_ypos(shot_ypos),
        .shots_left(shots_left),
        .out_of_ammo(out_of_ammo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int shot_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a timeline of edge indices rather than a state machine.
    // A rise sampled at edge n is acted on at edge n+1 if the controller is free
    // and has ammo. The shot fires at n+2, the controller is free again at
    // accept+C+2, and it reads empty from accept+C+1 when the last round is used.
    function automatic bit model_hit(int x, int y, int dx, int dy, bit act);
        return act && (x >= dx) && (x < dx + BOXW) && (y >= dy) && (y < dy + BOXH);
    endfunction

    int          e = 0;
    int          ammo = SPR;
    int          free_edge = 0;
    int          eval_edge = -1;
    int          empty_edge = NEVER;
    bit          m_valid = 0;
    bit          lq = 0;
    bit          rise_pend = 0;
    logic [11:0] px = '0, py = '0, lat_x = '0, lat_y = '0;
    bit          m_shot = 0, m_hit = 0, m_miss = 0;

    initial forever begin
        @(posedge clk);
        e++;
        m_shot = 0;
        m_hit  = 0;
        m_miss = 0;
        if (rst) begin
            m_valid    = 1;
            ammo       = SPR;
            free_edge  = 0;
            eval_edge  = -1;
            empty_edge = NEVER;
            lq         = 0;
            rise_pend  = 0;
            lat_x      = '0;
            lat_y      = '0;
        end else begin
            if (eval_edge == e) begin
                m_shot    = 1;
                m_hit     = model_hit(lat_x, lat_y, duck_xpos, duck_ypos, duck_active);
                m_miss    = !m_hit;
                eval_edge = -1;
            end
            if (round_start) begin
                ammo       = SPR;
                free_edge  = e + 1;
                empty_edge = NEVER;
            end else if (rise_pend && e >= free_edge && ammo > 0) begin
                lat_x     = px;
                lat_y     = py;
                eval_edge = e + 1;
                free_edge = e + C + 2;
`ifndef SHOT_CTL_INF_AMMO_EN
                ammo = ammo - 1;
                if (ammo == 0) empty_edge = e + C + 1;
`endif
            end
            rise_pend = mouse_left && !lq;
            lq        = mouse_left;
            px        = mouse_xpos;
            py        = mouse_ypos;
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid)
            check("model", {shot, hit, miss, shot_xpos, shot_ypos, shots_left, out_of_ammo},
                  {m_shot, m_hit, m_miss, lat_x, lat_y, 4'(ammo), (ammo == 0 && e >= empty_edge)});
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (shot === 1'b1) shot_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers; each is entered and left just after a falling edge.
    task automatic press(input logic [11:0] x, input logic [11:0] y);
        mouse_xpos = x;
        mouse_ypos = y;
        mouse_left = 1'b1;
        @(negedge clk);
        mouse_left = 1'b0;
    endtask

    task automatic pulse_rs();
        round_start = 1'b1;
        @(negedge clk);
        round_start = 1'b0;
    endtask

    typedef struct {
        logic [11:0] mx;
        logic [11:0] my;
        logic [11:0] dx;
        logic [11:0] dy;
        logic        act;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[8];
    int   s0;

    initial begin
        vecs[0] = '{130,  150, 100,  100, 1'b1, 1'b1};
        vecs[1] = '{164,  100, 100,  100, 1'b1, 1'b0};
        vecs[2] = '{100,  163, 100,  100, 1'b1, 1'b1};
        vecs[3] = '{4095, 10,  4090, 0,   1'b1, 1'b1};
        vecs[4] = '{130,  150, 100,  100, 1'b0, 1'b0};
        vecs[5] = '{99,   120, 100,  100, 1'b1, 1'b0};
        vecs[6] = '{163,  163, 100,  100, 1'b1, 1'b1};
        vecs[7] = '{120,  164, 100,  100, 1'b1, 1'b0};

        rst = 1'b1;
        mouse_left = 1'b0;
        mouse_xpos = '0;
        mouse_ypos = '0;
        duck_xpos = 12'd100;
        duck_ypos = 12'd100;
        duck_active = 1'b1;
        round_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_shot", shot, 0);
        check("rst_hit", hit, 0);
        check("rst_miss", miss, 0);
        check("rst_xpos", shot_xpos, 0);
        check("rst_ypos", shot_ypos, 0);
        check("rst_left", shots_left, SPR);
        check("rst_ooa", out_of_ammo, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            duck_xpos   = vecs[i].dx;
            duck_ypos   = vecs[i].dy;
            duck_active = vecs[i].act;
            pulse_rs();
            press(vecs[i].mx, vecs[i].my);
            @(negedge clk);
            check($sformatf("tbl%0d_noshot_yet", i), shot, 0);
            check($sformatf("tbl%0d_xpos", i), shot_xpos, vecs[i].mx);
            check($sformatf("tbl%0d_ypos", i), shot_ypos, vecs[i].my);
            check($sformatf("tbl%0d_left", i), shots_left, AMMO1);
            @(negedge clk);
            check($sformatf("tbl%0d_shot", i), shot, 1);
            check($sformatf("tbl%0d_hit", i), hit, vecs[i].exp_hit);
            check($sformatf("tbl%0d_miss", i), miss, !vecs[i].exp_hit);
            @(negedge clk);
            check($sformatf("tbl%0d_pulse_end", i), shot, 0);
            repeat (C + 2) @(negedge clk);
        end

        duck_xpos = 12'd100;
        duck_ypos = 12'd100;
        duck_active = 1'b1;

`ifdef SHOT_CTL_INF_AMMO_EN
        pulse_rs();
        s0 = shot_cnt;
        for (int i = 0; i < 5; i++) begin
            press(130, 150);
            repeat (C + 4) @(negedge clk);
        end
        check("inf_shots", shot_cnt - s0, 5);
        check("inf_left", shots_left, SPR);
        check("inf_ooa", out_of_ammo, 0);
`else
        pulse_rs();
        for (int i = 0; i < 3; i++) begin
            press(130, 150);
            @(negedge clk);
            check($sformatf("ammo_left%0d", i), shots_left, 2 - i);
            repeat (C + 3) @(negedge clk);
        end
        check("ammo_empty", out_of_ammo, 1);
        s0 = shot_cnt;
        press(130, 150);
        repeat (8) @(negedge clk);
        check("ammo_no_fourth", shot_cnt - s0, 0);
        check("ammo_still_empty", out_of_ammo, 1);
        pulse_rs();
        check("ammo_reload_left", shots_left, SPR);
        check("ammo_reload_ooa", out_of_ammo, 0);
`endif

        // Held trigger fires exactly once.
        pulse_rs();
        s0 = shot_cnt;
        mouse_xpos = 130;
        mouse_ypos = 150;
        mouse_left = 1'b1;
        repeat (20) @(negedge clk);
        mouse_left = 1'b0;
        repeat (C + 4) @(negedge clk);
        check("hold_one_shot", shot_cnt - s0, 1);

        // A press during cooldown is dropped; a later press fires.
        pulse_rs();
        s0 = shot_cnt;
        press(130, 150);
        repeat (2) @(negedge clk);
        check("cd_first", shot_cnt - s0, 1);
        press(140, 150);
        repeat (C + 4) @(negedge clk);
        check("cd_dropped", shot_cnt - s0, 1);
        press(150, 150);
        repeat (3) @(negedge clk);
        check("cd_after", shot_cnt - s0, 2);
        check("cd_after_x", shot_xpos, 150);
        repeat (C + 2) @(negedge clk);

        // Reload coincident with an accepted rising edge drops the click.
        s0 = shot_cnt;
        mouse_left = 1'b1;
        @(negedge clk);
        mouse_left = 1'b0;
        round_start = 1'b1;
        @(negedge clk);
        round_start = 1'b0;
        check("coin_left", shots_left, SPR);
        repeat (5) @(negedge clk);
        check("coin_no_shot", shot_cnt - s0, 0);

        // Reset while in EVAL suppresses the pulse.
        press(130, 150);
        @(negedge clk);
        check("rsteval_pre_left", shots_left, AMMO1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rsteval_shot", shot, 0);
        check("rsteval_hit", hit, 0);
        check("rsteval_miss", miss, 0);
        check("rsteval_xpos", shot_xpos, 0);
        check("rsteval_ypos", shot_ypos, 0);
        check("rsteval_left", shots_left, SPR);
        check("rsteval_ooa", out_of_ammo, 0);
        repeat (4) @(negedge clk);

        // Randomized run; the timeline model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                duck_xpos = 12'($urandom_range(0, 4095));
                duck_ypos = 12'($urandom_range(0, 4095));
            end
            duck_active = ($urandom_range(0, 3) != 0);
            mouse_xpos  = 12'(int'(duck_xpos) + int'($urandom_range(0, 90)) - 13);
            mouse_ypos  = 12'(int'(duck_ypos) + int'($urandom_range(0, 90)) - 13);
            if ($urandom_range(0, 3) == 0) mouse_left = ~mouse_left;
            round_start = ($urandom_range(0, 39) == 0);
            rst         = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        round_start = 1'b0;
        mouse_left = 1'b0;
        repeat (C + 4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
